// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF/ID 2-entry skid buffer with decoded fields (optional IF_ID_FLUSH_STATS_EN adds Flushed_Count)
module if_id_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] PC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] In_Instruction,
  input  logic [31:0] In_PC_Plus4,
  input  logic        Flush,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Instruction,
  output logic [31:0] Out_PC_Plus4,
  output logic [5:0]  Opcode,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [5:0]  Funct,
  output logic [15:0] Immediate_16
`ifdef IF_ID_FLUSH_STATS_EN
  ,
  output logic [15:0] Flushed_Count
`endif
);

  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] instr_mem [2];
  logic [31:0] pc_mem    [2];
  logic        push;
  logic        pop;

  // Handshakes depend only on registered occupancy, so no Out_Ready -> In_Ready path exists
  assign In_Ready  = (count != 2'd2);
  assign Out_Valid = (count != 2'd0);
  assign push      = In_Valid && In_Ready;
  assign pop       = Out_Valid && Out_Ready;

  // Occupancy and 1-bit wrapping pointers; Flush beats any same-cycle push or pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (Flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: contents are only visible while counted as valid
  always_ff @(posedge clk) begin
    if (push && !Flush) begin
      instr_mem[wr_ptr] <= In_Instruction;
      pc_mem[wr_ptr]    <= In_PC_Plus4;
    end
  end

  // Head entry, or the bubble values while empty
  always_comb begin
    Out_Instruction = NOP_INSTR;
    Out_PC_Plus4    = PC_RESET;
    if (Out_Valid) begin
      Out_Instruction = instr_mem[rd_ptr];
      Out_PC_Plus4    = pc_mem[rd_ptr];
    end
  end

  // Instruction field split for the decode stage
  always_comb begin
    Opcode       = Out_Instruction[31:26];
    Rs           = Out_Instruction[25:21];
    Rt           = Out_Instruction[20:16];
    Rd           = Out_Instruction[15:11];
    Funct        = Out_Instruction[5:0];
    Immediate_16 = Out_Instruction[15:0];
  end

`ifdef IF_ID_FLUSH_STATS_EN
  logic [16:0] flushed_sum;
  assign flushed_sum = {1'b0, Flushed_Count} + {15'd0, count};

  // Accumulate discarded valid entries per flush, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flushed_Count <= 16'd0;
    end else if (Flush) begin
      Flushed_Count <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
    end
  end
`endif

endmodule
